// File: rtl/ow_pkg.sv
// Shared definitions for the 1-Wire master datapath: default word width,
// reflected CRC-8 polynomial and the single-bit CRC-8 update step.
package ow_pkg;

    localparam int       OW_BYTE_W         = 8;
    localparam logic [7:0] OW_CRC8_POLY_REFL = 8'h8C;

    // One Dallas/Maxim CRC-8 step over a single bit, LSB-first order.
    function automatic logic [7:0] ow_crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[0] ^ din;
        return {1'b0, crc[7:1]} ^ (fb ? OW_CRC8_POLY_REFL : 8'h00);
    endfunction

endpackage

// File: rtl/ow_p2s_serializer.sv
// Double-buffered parallel-to-serial converter, LSB first, one bit per bit_req.
// An active stage (shift register + remaining-bit count) is backed by a single
// pending word so consecutive words stream with no gap. The running CRC-8 over
// consumed bits is present only when OW_P2S_CRC8_EN is defined; otherwise
// crc_out is tied to zero and crc_clr is ignored.
module ow_p2s_serializer
    import ow_pkg::*;
#(
    parameter  int DATA_W = OW_BYTE_W,
    localparam int LEN_W  = $clog2(DATA_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              bit_req,
    output logic              bit_valid,
    output logic              bit_value,
    output logic              bit_last,
    output logic              word_done,
    output logic              busy,
    output logic              underrun,
    input  logic              crc_clr,
    output logic [7:0]        crc_out
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(DATA_W);

    // Active and pending storage
    logic [DATA_W-1:0] sh_r;
    logic [LEN_W-1:0]  rem_r;
    logic [DATA_W-1:0] pd_data_r;
    logic [LEN_W-1:0]  pd_len_r;
    logic              pd_full_r;

    // Registered outputs
    logic              valid_r;
    logic              value_r;
    logic              last_r;
    logic              done_r;
    logic              busy_r;
    logic              underrun_r;

    // Next-state values
    logic              consume_s;
    logic              accept_s;
    logic              last_consume_s;
    logic [LEN_W-1:0]  len_eff_s;
    logic [DATA_W-1:0] sh_nxt_s;
    logic [LEN_W-1:0]  rem_nxt_s;
    logic [DATA_W-1:0] pd_data_nxt_s;
    logic [LEN_W-1:0]  pd_len_nxt_s;
    logic              pd_full_nxt_s;
    logic              underrun_nxt_s;

    // Next-state decode: consume, promotion of the pending word, and load routing
    always_comb begin
        consume_s      = bit_req & (rem_r != LEN_ZERO);
        accept_s       = load_valid & ~pd_full_r;
        last_consume_s = consume_s & (rem_r == LEN_ONE);

        // Zero and oversize lengths both mean a full word.
        if ((load_len == LEN_ZERO) || (load_len > LEN_FULL)) begin
            len_eff_s = LEN_FULL;
        end else begin
            len_eff_s = load_len;
        end

        sh_nxt_s      = sh_r;
        rem_nxt_s     = rem_r;
        pd_data_nxt_s = pd_data_r;
        pd_len_nxt_s  = pd_len_r;
        pd_full_nxt_s = pd_full_r;

        if (consume_s) begin
            sh_nxt_s  = {1'b0, sh_r[DATA_W-1:1]};
            rem_nxt_s = rem_r - LEN_ONE;
        end else begin
            sh_nxt_s  = sh_r;
            rem_nxt_s = rem_r;
        end

        // Last bit gone and a word is waiting: promote it without a bubble.
        if (last_consume_s && pd_full_r) begin
            sh_nxt_s      = pd_data_r;
            rem_nxt_s     = pd_len_r;
            pd_full_nxt_s = 1'b0;
        end else begin
            pd_full_nxt_s = pd_full_r;
        end

        // A new word bypasses the pending buffer whenever the active stage
        // is (or is about to become) empty; pd_full is 0 whenever accept_s is 1.
        if (accept_s) begin
            if ((rem_r == LEN_ZERO) || last_consume_s) begin
                sh_nxt_s  = load_data;
                rem_nxt_s = len_eff_s;
            end else begin
                pd_data_nxt_s = load_data;
                pd_len_nxt_s  = len_eff_s;
                pd_full_nxt_s = 1'b1;
            end
        end else begin
            pd_data_nxt_s = pd_data_nxt_s;
        end

        // Underrun is sticky until a word is accepted.
        if (accept_s) begin
            underrun_nxt_s = 1'b0;
        end else if (bit_req && (rem_r == LEN_ZERO)) begin
            underrun_nxt_s = 1'b1;
        end else begin
            underrun_nxt_s = underrun_r;
        end
    end

    // Datapath and registered output update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_r       <= {DATA_W{1'b0}};
            rem_r      <= LEN_ZERO;
            pd_data_r  <= {DATA_W{1'b0}};
            pd_len_r   <= LEN_ZERO;
            pd_full_r  <= 1'b0;
            valid_r    <= 1'b0;
            value_r    <= 1'b0;
            last_r     <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            sh_r       <= sh_nxt_s;
            rem_r      <= rem_nxt_s;
            pd_data_r  <= pd_data_nxt_s;
            pd_len_r   <= pd_len_nxt_s;
            pd_full_r  <= pd_full_nxt_s;
            valid_r    <= (rem_nxt_s != LEN_ZERO);
            value_r    <= (rem_nxt_s != LEN_ZERO) & sh_nxt_s[0];
            last_r     <= (rem_nxt_s == LEN_ONE);
            done_r     <= last_consume_s;
            busy_r     <= (rem_nxt_s != LEN_ZERO) | pd_full_nxt_s;
            underrun_r <= underrun_nxt_s;
        end
    end

    assign load_ready = ~pd_full_r;
    assign bit_valid  = valid_r;
    assign bit_value  = value_r;
    assign bit_last   = last_r;
    assign word_done  = done_r;
    assign busy       = busy_r;
    assign underrun   = underrun_r;

`ifdef OW_P2S_CRC8_EN
    logic [7:0] crc_r;

    // CRC-8 accumulation over consumed bits; clear wins over an update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_r <= 8'h00;
        end else if (crc_clr) begin
            crc_r <= 8'h00;
        end else if (consume_s) begin
            crc_r <= ow_crc8_step(crc_r, sh_r[0]);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc_out = crc_r;
`else
    logic crc_unused_s;
    assign crc_unused_s = crc_clr;
    assign crc_out      = 8'h00;
`endif

endmodule

// File: tb/tb_ow_p2s_serializer.sv
// Directed self-checking bench for ow_p2s_serializer (DATA_W = 8).
module tb_ow_p2s_serializer;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_valid = 1'b0;
    logic              load_ready;
    logic [DATA_W-1:0] load_data = 8'h00;
    logic [LEN_W-1:0]  load_len = 4'd0;
    logic              bit_req = 1'b0;
    logic              bit_valid;
    logic              bit_value;
    logic              bit_last;
    logic              word_done;
    logic              busy;
    logic              underrun;
    logic              crc_clr = 1'b0;
    logic [7:0]        crc_out;

    int total = 0;
    int bad   = 0;

    ow_p2s_serializer #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_len(load_len),
        .bit_req(bit_req), .bit_valid(bit_valid), .bit_value(bit_value),
        .bit_last(bit_last), .word_done(word_done), .busy(busy),
        .underrun(underrun), .crc_clr(crc_clr), .crc_out(crc_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Load one word and consume its bits back-to-back with no checks.
    task automatic send_word(input logic [7:0] d, input logic [3:0] len, input int nbits);
        load_valid = 1'b1; load_data = d; load_len = len;
        step();
        load_valid = 1'b0;
        bit_req = 1'b1;
        repeat (nbits) step();
        bit_req = 1'b0;
    endtask

    logic [7:0]  pat;
    logic [15:0] pat16;

    initial begin
        // Reset state
        #12;
        chk("rst_load_ready", load_ready, 1);
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_bit_value", bit_value, 0);
        chk("rst_bit_last", bit_last, 0);
        chk("rst_word_done", word_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_crc", crc_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single byte A5, full length, spaced requests
        pat = 8'hA5;
        load_valid = 1'b1; load_data = pat; load_len = 4'd0;
        step();
        load_valid = 1'b0;
        chk("a5_valid_lat1", bit_valid, 1);
        chk("a5_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("a5_bit%0d", i), bit_value, pat[i]);
            chk($sformatf("a5_last%0d", i), bit_last, (i == 7));
            bit_req = 1'b1;
            step();
            bit_req = 1'b0;
            chk($sformatf("a5_done%0d", i), word_done, (i == 7));
            step();
            step();
        end
        chk("a5_done_cleared", word_done, 0);
        chk("a5_busy_end", busy, 0);
        chk("a5_valid_end", bit_valid, 0);

        // Back-to-back 01 then FF with the second held pending
        pat16 = 16'hFF01;
        load_valid = 1'b1; load_data = 8'h01; load_len = 4'd0;
        step();
        load_data = 8'hFF;
        step();
        load_valid = 1'b0;
        chk("b2b_ready_pending", load_ready, 0);
        chk("b2b_busy", busy, 1);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("b2b_valid%0d", i), bit_valid, 1);
            chk($sformatf("b2b_bit%0d", i), bit_value, pat16[i]);
            chk($sformatf("b2b_last%0d", i), bit_last, (i == 7 || i == 15));
            chk($sformatf("b2b_ready%0d", i), load_ready, (i >= 8));
            bit_req = 1'b1;
            step();
            chk($sformatf("b2b_done%0d", i), word_done, (i == 7 || i == 15));
        end
        bit_req = 1'b0;
        chk("b2b_valid_end", bit_valid, 0);
        chk("b2b_busy_end", busy, 0);

        // Partial length 3 of 8'h06
        pat = 8'h06;
        load_valid = 1'b1; load_data = pat; load_len = 4'd3;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("len3_bit%0d", i), bit_value, pat[i]);
            chk($sformatf("len3_last%0d", i), bit_last, (i == 2));
            bit_req = 1'b1;
            step();
        end
        bit_req = 1'b0;
        chk("len3_done", word_done, 1);
        chk("len3_idle", bit_valid, 0);

        // Length 12 clamps to 8: MSB of 8'h80 is the final bit
        pat = 8'h80;
        load_valid = 1'b1; load_data = pat; load_len = 4'd12;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("clamp_bit%0d", i), bit_value, pat[i]);
            chk($sformatf("clamp_last%0d", i), bit_last, (i == 7));
            bit_req = 1'b1;
            step();
        end
        bit_req = 1'b0;
        chk("clamp_done", word_done, 1);
        chk("clamp_idle", busy, 0);

        // Underrun: request while idle, sticky, cleared by next load
        chk("ur_before", underrun, 0);
        bit_req = 1'b1;
        step();
        bit_req = 1'b0;
        chk("ur_set", underrun, 1);
        chk("ur_no_valid", bit_valid, 0);
        chk("ur_no_done", word_done, 0);
        step();
        chk("ur_sticky", underrun, 1);
        load_valid = 1'b1; load_data = 8'h03; load_len = 4'd2;
        step();
        load_valid = 1'b0;
        chk("ur_cleared", underrun, 0);
        chk("ur_word_bit0", bit_value, 1);
        bit_req = 1'b1;
        step();
        chk("ur_word_bit1", bit_value, 1);
        chk("ur_word_last", bit_last, 1);
        step();
        bit_req = 1'b0;
        chk("ur_word_done", word_done, 1);

        // Bypass: last-bit consume and a new load in the same cycle
        load_valid = 1'b1; load_data = 8'h01; load_len = 4'd1;
        step();
        chk("byp_single_last", bit_last, 1);
        load_data = 8'h02; load_len = 4'd2;
        bit_req = 1'b1;
        step();
        load_valid = 1'b0;
        chk("byp_done", word_done, 1);
        chk("byp_valid", bit_valid, 1);
        chk("byp_bit0", bit_value, 0);
        chk("byp_ready", load_ready, 1);
        step();
        chk("byp_bit1", bit_value, 1);
        chk("byp_last", bit_last, 1);
        step();
        bit_req = 1'b0;
        chk("byp_done2", word_done, 1);
        chk("byp_idle", busy, 0);

        // Reset mid-word after 4 of 8 bits
        load_valid = 1'b1; load_data = 8'hA5; load_len = 4'd0;
        step();
        load_valid = 1'b0;
        bit_req = 1'b1;
        repeat (4) step();
        bit_req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", bit_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_value", bit_value, 0);
        chk("mrst_done", word_done, 0);
        chk("mrst_ready", load_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("mrst_after_done", word_done, 0);
        chk("mrst_after_ready", load_ready, 1);
        chk("mrst_after_valid", bit_valid, 0);

`ifdef OW_P2S_CRC8_EN
        // CRC over the ROM example, then the CRC byte itself
        crc_clr = 1'b1;
        step();
        crc_clr = 1'b0;
        send_word(8'h02, 4'd0, 8);
        send_word(8'h1C, 4'd0, 8);
        send_word(8'hB8, 4'd0, 8);
        send_word(8'h01, 4'd0, 8);
        send_word(8'h00, 4'd0, 8);
        send_word(8'h00, 4'd0, 8);
        send_word(8'h00, 4'd0, 8);
        chk("crc_rom", crc_out, 8'hA2);
        send_word(8'hA2, 4'd0, 8);
        chk("crc_residue", crc_out, 8'h00);
        // Clear beats a same-cycle update; next 1-bit from zero gives 8C
        load_valid = 1'b1; load_data = 8'hFF; load_len = 4'd0;
        step();
        load_valid = 1'b0;
        bit_req = 1'b1; crc_clr = 1'b1;
        step();
        crc_clr = 1'b0;
        chk("crc_clr_prio", crc_out, 8'h00);
        step();
        chk("crc_one_bit", crc_out, 8'h8C);
        repeat (6) step();
        bit_req = 1'b0;
        chk("crc_drain_idle", busy, 0);
`else
        send_word(8'h5A, 4'd0, 8);
        crc_clr = 1'b1;
        step();
        crc_clr = 1'b0;
        chk("crc_tied_zero", crc_out, 8'h00);
        chk("crc_off_idle", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
